// File: rtl/w_wb_queue_pkg.sv
// Shared sizing constants and the entry layout for the W-stage write-back queue.
package w_wb_queue_pkg;

  localparam int WBQ_DEPTH = 4;
  localparam int WBQ_PTR_W = 2;

  typedef struct packed {
    logic        valid;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } wbq_entry_t;

  // Register $0 is never written, so a zero address marks an idle request.
  function automatic logic req_active(input logic v, input logic [4:0] a);
    return v && (a != 5'd0);
  endfunction

endpackage

// File: rtl/w_wb_queue.sv
// Register-file write arbiter: the pipeline W stage always wins, late producers are
// queued and drained on idle cycles, and stale queued writes are squashed by newer W writes.
module w_wb_queue
  import w_wb_queue_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH,
  parameter int PTR_W = WBQ_PTR_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic [31:0] a_pc,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  input  logic [31:0] b_pc,
  output logic        b_ready,
  output logic [4:0]  A3,
  output logic [31:0] WD,
  output logic [31:0] WPC,
  input  logic [4:0]  q_addr1,
  input  logic [4:0]  q_addr2,
  output logic        busy1,
  output logic        busy2,
  output logic [2:0]  count
);

  localparam logic [2:0]       DEPTH_C  = 3'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  // Handshake: a b request transfers on a posedge where b_valid && b_ready; b_ready
  // depends only on registered occupancy, never on this cycle's pop or A traffic.

  wbq_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             a_act;
  logic             b_act;
  logic             empty;
  logic             push;
  logic             pop;
  wbq_entry_t       head;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign a_act   = req_active(a_valid, a_addr);
  assign b_act   = req_active(b_valid, b_addr);
  assign empty   = (count == 3'd0);
  assign b_ready = (count < DEPTH_C);
  assign push    = b_act && b_ready;
  assign pop     = !a_act && !empty;
  assign head    = mem[rd_ptr];

  // A squashed head still consumes its slot, but drives a null write.
  always_comb begin
    A3  = '0;
    WD  = '0;
    WPC = '0;
    if (a_act) begin
      A3  = a_addr;
      WD  = a_data;
      WPC = a_pc;
    end else if (!empty && !reset && head.valid) begin
      A3  = head.addr;
      WD  = head.data;
      WPC = head.pc;
    end
  end

  // Valid bits outside the occupied window are always clear, so a full scan is exact.
  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i].valid && (q_addr1 != 5'd0) && (mem[i].addr == q_addr1)) busy1 = 1'b1;
      if (mem[i].valid && (q_addr2 != 5'd0) && (mem[i].addr == q_addr2)) busy2 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (a_act && (mem[i].addr == a_addr)) mem[i].valid <= 1'b0;
      end
      if (pop) begin
        mem[rd_ptr].valid <= 1'b0;
        rd_ptr            <= ptr_next(rd_ptr);
      end
      // Written last so a same-cycle push is younger than the A write and survives.
      if (push) begin
        mem[wr_ptr].valid <= 1'b1;
        mem[wr_ptr].addr  <= b_addr;
        mem[wr_ptr].data  <= b_data;
        mem[wr_ptr].pc    <= b_pc;
        wr_ptr            <= ptr_next(wr_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_w_wb_queue.sv
// Bench for w_wb_queue: directed scenarios plus random traffic against a queue-based model.
module tb_w_wb_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr, q_addr1, q_addr2;
  logic [31:0] a_data, a_pc, b_data, b_pc;
  logic        b_ready, busy1, busy2;
  logic [4:0]  A3;
  logic [31:0] WD, WPC;
  logic [2:0]  count;

  always #5 clk = ~clk;

  w_wb_queue dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_pc(a_pc),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_pc(b_pc),
    .b_ready(b_ready), .A3(A3), .WD(WD), .WPC(WPC),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .busy1(busy1), .busy2(busy2),
    .count(count)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
    bit          valid;
  } ment_t;

  ment_t       mq[$];
  logic [74:0] exp_q[$];
  logic [74:0] exp_v;
  logic [31:0] rf_obs [32];
  int          n_checks = 0;
  int          n_err = 0;

  wire [74:0] obs_vec = {A3, WD, WPC, b_ready, busy1, busy2, count};

  // Expected outputs for the current inputs, derived from the queue contents.
  task automatic model_eval();
    logic [4:0]  e_a3 = '0;
    logic [31:0] e_wd = '0, e_wpc = '0;
    logic        e_b1 = 1'b0, e_b2 = 1'b0;
    if (a_valid && a_addr != 0) begin
      e_a3 = a_addr; e_wd = a_data; e_wpc = a_pc;
    end else if (!reset && mq.size() > 0 && mq[0].valid) begin
      e_a3 = mq[0].addr; e_wd = mq[0].data; e_wpc = mq[0].pc;
    end
    foreach (mq[i]) begin
      if (mq[i].valid && q_addr1 != 0 && mq[i].addr == q_addr1) e_b1 = 1'b1;
      if (mq[i].valid && q_addr2 != 0 && mq[i].addr == q_addr2) e_b2 = 1'b1;
    end
    exp_q.push_back({e_a3, e_wd, e_wpc, (mq.size() < 4), e_b1, e_b2, 3'(mq.size())});
  endtask

  task automatic model_commit();
    bit a_act = a_valid && a_addr != 0;
    bit b_act = b_valid && b_addr != 0;
    int sz = mq.size();
    if (reset) begin
      mq.delete();
    end else begin
      if (!a_act && sz > 0) mq.delete(0);
      if (a_act) foreach (mq[i]) if (mq[i].addr == a_addr) mq[i].valid = 0;
      if (b_act && sz < 4) mq.push_back('{b_addr, b_data, b_pc, 1'b1});
    end
  endtask

  task automatic drive(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic [4:0] q1, input logic [4:0] q2);
    reset = r; a_valid = av; a_addr = aa; a_data = ad; a_pc = ad ^ 32'hA000_0000;
    b_valid = bv; b_addr = ba; b_data = bd; b_pc = bd ^ 32'hB000_0000;
    q_addr1 = q1; q_addr2 = q2;
    model_eval();
    exp_v = exp_q.pop_front();
    @(negedge clk);
    if (A3 != 0) rf_obs[A3] = WD;
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    drive(1, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 5'd4, 5'd0);
    n_checks++;
    if (obs_vec !== exp_v) begin n_err++; $display("FAIL reset_passthru: got %h exp %h", obs_vec, exp_v); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 5'd4, 5'd0);
    n_checks++;
    if (obs_vec !== exp_v) begin n_err++; $display("FAIL reset_state: got %h exp %h", obs_vec, exp_v); end
    n_checks++;
    if (count !== 3'd0 || b_ready !== 1'b1 || busy1 !== 1'b0) begin
      n_err++; $display("FAIL reset_regs: got count=%0d rdy=%b busy1=%b exp 0/1/0", count, b_ready, busy1);
    end
    advance();
  endtask

  task automatic test_a_write();
    drive(0, 1, 5'd5, 32'h11, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs_vec !== exp_v) begin n_err++; $display("FAIL a_write: got %h exp %h", obs_vec, exp_v); end
    n_checks++;
    if (A3 !== 5'd5 || WD !== 32'h11 || count !== 3'd0) begin
      n_err++; $display("FAIL a_write_const: got A3=%0d WD=%h count=%0d exp 5/11/0", A3, WD, count);
    end
    advance();
  endtask

  task automatic test_b_push();
    drive(0, 0, 0, 0, 1, 5'd8, 32'hAA, 5'd8, 5'd0);
    n_checks++;
    if (obs_vec !== exp_v || busy1 !== 1'b0 || A3 !== 5'd0) begin
      n_err++; $display("FAIL b_push_c0: got %h exp %h", obs_vec, exp_v);
    end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 5'd8, 5'd0);
    n_checks++;
    if (obs_vec !== exp_v || A3 !== 5'd8 || WD !== 32'hAA || busy1 !== 1'b1 || count !== 3'd1) begin
      n_err++; $display("FAIL b_push_c1: got %h exp %h", obs_vec, exp_v);
    end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 5'd8, 5'd0);
    n_checks++;
    if (obs_vec !== exp_v || busy1 !== 1'b0 || count !== 3'd0) begin
      n_err++; $display("FAIL b_push_c2: got %h exp %h", obs_vec, exp_v);
    end
    advance();
  endtask

  task automatic test_fill_drain();
    for (int k = 1; k <= 5; k++) begin
      drive(0, 1, 5'd9, 32'h90 + k, 1, 5'(k), 32'hB0 + k, 5'd4, 5'd5);
      n_checks++;
      if (obs_vec !== exp_v) begin n_err++; $display("FAIL fill_%0d: got %h exp %h", k, obs_vec, exp_v); end
      if (k == 5) begin
        n_checks++;
        if (count !== 3'd4 || b_ready !== 1'b0) begin
          n_err++; $display("FAIL fill_full: got count=%0d rdy=%b exp 4/0", count, b_ready);
        end
      end
      advance();
    end
    for (int k = 1; k <= 5; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 5'd4, 5'd5);
      n_checks++;
      if (obs_vec !== exp_v) begin n_err++; $display("FAIL drain_%0d: got %h exp %h", k, obs_vec, exp_v); end
      n_checks++;
      if (k <= 4 && (A3 !== 5'(k) || WD !== 32'hB0 + k)) begin
        n_err++; $display("FAIL drain_order_%0d: got A3=%0d WD=%h exp %0d/%h", k, A3, WD, k, 32'hB0 + k);
      end else if (k == 5 && (A3 !== 5'd0 || count !== 3'd0)) begin
        n_err++; $display("FAIL drain_empty: got A3=%0d count=%0d exp 0/0", A3, count);
      end
      advance();
    end
  endtask

  task automatic test_squash();
    drive(0, 0, 0, 0, 1, 5'd6, 32'h1, 5'd6, 5'd7);
    n_checks++;
    if (obs_vec !== exp_v) begin n_err++; $display("FAIL squash_push: got %h exp %h", obs_vec, exp_v); end
    advance();
    drive(0, 1, 5'd6, 32'h2, 0, 0, 0, 5'd6, 5'd7);
    n_checks++;
    if (obs_vec !== exp_v || busy1 !== 1'b1) begin n_err++; $display("FAIL squash_awrite: got %h exp %h", obs_vec, exp_v); end
    advance();
    drive(0, 1, 5'd7, 32'h70, 1, 5'd7, 32'h77, 5'd6, 5'd7);
    n_checks++;
    if (obs_vec !== exp_v || busy1 !== 1'b0) begin n_err++; $display("FAIL squash_same_cycle: got %h exp %h", obs_vec, exp_v); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 5'd6, 5'd7);
    n_checks++;
    if (obs_vec !== exp_v || A3 !== 5'd0 || busy1 !== 1'b0 || busy2 !== 1'b1 || count !== 3'd2) begin
      n_err++; $display("FAIL squash_slot: got %h exp %h", obs_vec, exp_v);
    end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 5'd6, 5'd7);
    n_checks++;
    if (obs_vec !== exp_v || A3 !== 5'd7 || WD !== 32'h77) begin
      n_err++; $display("FAIL squash_younger: got %h exp %h", obs_vec, exp_v);
    end
    advance();
    n_checks++;
    if (rf_obs[6] !== 32'h2 || rf_obs[7] !== 32'h77) begin
      n_err++; $display("FAIL squash_final: got r6=%h r7=%h exp 2/77", rf_obs[6], rf_obs[7]);
    end
  endtask

  task automatic test_zero_and_reset();
    drive(0, 0, 0, 0, 1, 5'd0, 32'hDEAD, 0, 0);
    n_checks++;
    if (obs_vec !== exp_v) begin n_err++; $display("FAIL zero_b: got %h exp %h", obs_vec, exp_v); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (count !== 3'd0 || b_ready !== 1'b1 || A3 !== 5'd0) begin
      n_err++; $display("FAIL zero_b_nopush: got count=%0d rdy=%b A3=%0d exp 0/1/0", count, b_ready, A3);
    end
    advance();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 5'd9, 32'h9, 1, 5'(k + 10), 32'hC0 + k, 5'd11, 5'd0);
      advance();
    end
    drive(1, 0, 0, 0, 1, 5'd12, 32'hEE, 5'd11, 5'd0);
    n_checks++;
    if (obs_vec !== {5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 3'd3} || obs_vec !== exp_v) begin
      n_err++; $display("FAIL reset_mid: got %h exp %h", obs_vec, exp_v);
    end
    advance();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 5'd11, 5'd12);
      n_checks++;
      if (A3 !== 5'd0 || count !== 3'd0 || busy1 !== 1'b0 || busy2 !== 1'b0 || obs_vec !== exp_v) begin
        n_err++; $display("FAIL reset_drop_%0d: got %h exp %h", k, obs_vec, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 4) < 2, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 4) < 3, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      n_checks++;
      if (obs_vec !== exp_v) begin n_err++; $display("FAIL random_%0d: got %h exp %h", n, obs_vec, exp_v); end
      advance();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_obs[i] = '0;
    reset = 1'b1; a_valid = 0; a_addr = 0; a_data = 0; a_pc = 0;
    b_valid = 0; b_addr = 0; b_data = 0; b_pc = 0; q_addr1 = 0; q_addr2 = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_a_write();
    test_b_push();
    test_fill_drain();
    test_squash();
    test_zero_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish exp finish within 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/w_wb_queue.md
W_WB_QUEUE -- requirements
Module: W_WB_QUEUE

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset sampled on posedge clk.
REQ-003 SHALL have ports a_valid/a_addr/a_data/a_pc, input, 1/5/32/32, pipeline W-stage write request; never stalled.
REQ-004 SHALL have ports b_valid/b_addr/b_data/b_pc, input, 1/5/32/32, late-producer write request (e.g. MDU).
REQ-005 SHALL have port b_ready, output, 1, high when queue can accept a b request this cycle.
REQ-006 SHALL have ports A3/WD/WPC, output, 5/32/32, write port driving register file; A3==0 means no write.
REQ-007 SHALL have ports q_addr1/q_addr2, input, 5 each, and busy1/busy2, output, 1 each, decode-stage pending-write query.
REQ-008 SHALL have port count, output, 3, current queue occupancy 0..4.
REQ-009 SHALL have parameter DEPTH, default 4, queue entries; pointers wrap modulo DEPTH.

Function
REQ-010 SHALL treat a request as active only when valid==1 and addr!=0; a_valid with a_addr==0 is idle.
REQ-011 SHALL, when A active, drive A3/WD/WPC from a_addr/a_data/a_pc combinationally in the same cycle (0-cycle latency).
REQ-012 SHALL, when A idle and queue non-empty, drive outputs from queue head and pop head that cycle.
REQ-013 SHALL drive A3=0, WD=0, WPC=0 when A idle and queue empty.
REQ-014 SHALL push an active b request on posedge when b_ready==1; b_ready = (count < DEPTH), independent of this cycle's pop.
REQ-015 SHALL accept and discard b requests with b_addr==0 (b_ready unaffected, no push).
REQ-016 SHALL allow push and pop in the same cycle; count unchanged.
REQ-017 SHALL never write a b request straight through; minimum B-to-A3 latency is 1 cycle.
REQ-018 SHALL, when A active with a_addr==r, clear the valid bit of every queued entry with addr r (WAW squash; older entry must not overwrite newer).
REQ-019 SHALL treat a b request pushed in the same cycle as an A write to the same r as younger; it is not squashed.
REQ-020 SHALL, when head entry is squashed and A idle, pop it with A3=0 (one cycle consumed, no write).
REQ-021 SHALL assert busyN when q_addrN!=0 and any valid queued entry has addr q_addrN; squashed entries not counted; incoming same-cycle b request not counted.
REQ-022 SHALL keep count equal to entries between pointers, including squashed entries.

Reset
REQ-023 SHALL on reset clear read/write pointers, count=0, all entry valid bits=0; b_ready=1 and busy1/busy2=0 the following cycle.
REQ-024 SHALL on reset mid-operation drop all queued entries without writing them; a request presented in the reset cycle is not pushed.
REQ-025 SHALL still pass A combinationally to A3/WD/WPC during reset (register file applies its own reset priority).

Structure
REQ-026 SHALL take DEPTH default and pointer width from shared header def.v (`WBQ_DEPTH`, `WBQ_PTR_W`).
REQ-027 SHALL keep queue storage (addr/data/pc/valid per entry) inside this module; no sub-module required; arbitration mux and scoreboard compare in same file.

Verification
REQ-028 SHALL cover: A write $5<=0x11 with queue empty -> A3=5, WD=0x11 same cycle, count=0.
REQ-029 SHALL cover: b pushes $8<=0xAA while A idle -> next cycle A3=8, WD=0xAA, count 1->0; busy for q_addr1=8 high exactly 1 cycle.
REQ-030 SHALL cover: 4 b pushes $1..$4 while A active on $9 -> count=4, b_ready=0, 5th b request not pushed; A idle drains $1,$2,$3,$4 in order.
REQ-031 SHALL cover: queue holds $6<=0x1, A writes $6<=0x2 -> entry squashed, busy(6)=0 next cycle, drain emits A3=0 for that slot; final $6 value 0x2.
REQ-032 SHALL cover: b_addr=0 request -> no push, count stays 0; reset with count=3 -> count=0, no queued writes ever appear on A3.
